// File: rtl/sdram_pro_pkg.sv
`default_nettype none
// ============================================================================
// sdram_pro_pkg : shared SDRAM command, NOP-bus and FSM-state constants
// Rev 1.0 - initial release
// ============================================================================
package sdram_pro_pkg;

  // Command encodings, {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] c_cmd_nop        = 4'b0111;
  localparam logic [3:0] c_cmd_precharge  = 4'b0010;
  localparam logic [3:0] c_cmd_auto_ref   = 4'b0001;

  // Idle bus values; address is sliced down to the instantiated ADDR_W (<= 32)
  localparam logic [1:0]  c_nop_bank = 2'b11;
  localparam logic [31:0] c_nop_addr = 32'hFFFF_FFFF;

  // Arbiter FSM state encoding
  localparam logic [2:0] c_st_init  = 3'd0;
  localparam logic [2:0] c_st_arbit = 3'd1;
  localparam logic [2:0] c_st_atref = 3'd2;
  localparam logic [2:0] c_st_write = 3'd3;
  localparam logic [2:0] c_st_read  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sdram_pro_arbit_sel.sv
`default_nettype none
// ============================================================================
// sdram_pro_arbit_sel : refresh > write/read request selector
// Build option SDRAM_PRO_ARBIT_RR_EN alternates write/read when both pend.
// Rev 1.0 - initial release
// ============================================================================
module sdram_pro_arbit_sel (
`ifdef SDRAM_PRO_ARBIT_RR_EN
  input  logic sys_clk,
  input  logic sys_rst,
`endif
  input  logic arb_ok,
  input  logic atref_req,
  input  logic wr_req,
  input  logic rd_req,
  output logic sel_atref,
  output logic sel_wr,
  output logic sel_rd
);

  assign sel_atref = arb_ok & atref_req;

`ifdef SDRAM_PRO_ARBIT_RR_EN
  // 0: write wins a write/read tie, 1: read wins
  logic r_rr_ptr;

  assign sel_wr = arb_ok & ~atref_req & wr_req & ~(rd_req &  r_rr_ptr);
  assign sel_rd = arb_ok & ~atref_req & rd_req & ~(wr_req & ~r_rr_ptr);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (sel_wr | sel_rd) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end
`else
  assign sel_wr = arb_ok & ~atref_req & wr_req;
  assign sel_rd = arb_ok & ~atref_req & ~wr_req & rd_req;
`endif

endmodule
`default_nettype wire

// File: rtl/sdram_pro_arbit.sv
`default_nettype none
// ============================================================================
// sdram_pro_arbit : SDRAM bus owner FSM and command/address/DQ output mux
// Build option SDRAM_PRO_ARBIT_RR_EN enables write/read round-robin.
// Rev 1.0 - initial release
// ============================================================================
module sdram_pro_arbit
  import sdram_pro_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              atref_req,
  input  logic              atref_end,
  input  logic [3:0]        atref_cmd,
  input  logic [1:0]        atref_bank,
  input  logic [ADDR_W-1:0] atref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dq,
  input  logic              wr_dq_oe,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              atref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [1:0]        sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_hold;
  logic       w_arb_ok;
  logic       w_burst_done;
  logic       w_sel_atref;
  logic       w_sel_wr;
  logic       w_sel_rd;

  // The first ARBIT cycle after a burst never grants
  assign w_arb_ok = (r_state == c_st_arbit) & ~r_hold & ~sys_rst;

  assign w_burst_done = ((r_state == c_st_atref) & atref_end) |
                        ((r_state == c_st_write) & wr_end)    |
                        ((r_state == c_st_read)  & rd_end);

  sdram_pro_arbit_sel u_sel (
`ifdef SDRAM_PRO_ARBIT_RR_EN
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
`endif
    .arb_ok    (w_arb_ok),
    .atref_req (atref_req),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .sel_atref (w_sel_atref),
    .sel_wr    (w_sel_wr),
    .sel_rd    (w_sel_rd)
  );

  assign atref_en = w_sel_atref;
  assign wr_en    = w_sel_wr;
  assign rd_en    = w_sel_rd;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_init: begin
        if (init_end) w_next = c_st_arbit;
      end
      c_st_arbit: begin
        if (w_sel_atref)      w_next = c_st_atref;
        else if (w_sel_wr)    w_next = c_st_write;
        else if (w_sel_rd)    w_next = c_st_read;
      end
      c_st_atref, c_st_write, c_st_read: begin
        if (w_burst_done) w_next = c_st_arbit;
      end
      default: w_next = c_st_init;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= c_st_init;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_burst_done;
    end
  end

  // Reset hands the bus straight back to the init stage
  always_comb begin
    sdram_cmd    = c_cmd_nop;
    sdram_bank   = c_nop_bank;
    sdram_addr   = c_nop_addr[ADDR_W-1:0];
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    if (sys_rst) begin
      sdram_cmd  = init_cmd;
      sdram_bank = init_bank;
      sdram_addr = init_addr;
    end else begin
      case (r_state)
        c_st_init: begin
          sdram_cmd  = init_cmd;
          sdram_bank = init_bank;
          sdram_addr = init_addr;
        end
        c_st_atref: begin
          sdram_cmd  = atref_cmd;
          sdram_bank = atref_bank;
          sdram_addr = atref_addr;
        end
        c_st_write: begin
          sdram_cmd    = wr_cmd;
          sdram_bank   = wr_bank;
          sdram_addr   = wr_addr;
          sdram_dq_out = wr_dq;
          sdram_dq_oe  = wr_dq_oe;
        end
        c_st_read: begin
          sdram_cmd  = rd_cmd;
          sdram_bank = rd_bank;
          sdram_addr = rd_addr;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_pro_arbit.sv
`default_nettype none
// ============================================================================
// tb_sdram_pro_arbit : randomized bench against a bus-ownership reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_sdram_pro_arbit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int N_CYC  = 4000;

  // Owner codes used only by the reference model
  localparam int OWN_INIT  = 0;
  localparam int OWN_IDLE  = 1;
  localparam int OWN_ATREF = 2;
  localparam int OWN_WR    = 3;
  localparam int OWN_RD    = 4;

  logic              sys_clk;
  logic              sys_rst;
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              atref_req, atref_end;
  logic [3:0]        atref_cmd;
  logic [1:0]        atref_bank;
  logic [ADDR_W-1:0] atref_addr;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dq;
  logic              wr_dq_oe;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              atref_en, wr_en, rd_en;
  logic [3:0]        sdram_cmd;
  logic [1:0]        sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  int n_total;
  int n_bad;

  // Reference model state
  int m_owner;
  bit m_cool;     // one quiet arbitration cycle after a burst
  bit m_rd_turn;  // round-robin: read wins the next write/read tie
  int m_grant;    // owner granted in the current cycle, OWN_IDLE if none

  sdram_pro_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .atref_req(atref_req), .atref_end(atref_end), .atref_cmd(atref_cmd),
    .atref_bank(atref_bank), .atref_addr(atref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank),
    .rd_addr(rd_addr),
    .atref_en(atref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Who should be granted right now, given the model's view of the bus
  function automatic int pick_grant();
    if (sys_rst || m_owner != OWN_IDLE || m_cool) return OWN_IDLE;
    if (atref_req) return OWN_ATREF;
    if (wr_req && rd_req) begin
`ifdef SDRAM_PRO_ARBIT_RR_EN
      return m_rd_turn ? OWN_RD : OWN_WR;
`else
      return OWN_WR;
`endif
    end
    if (wr_req) return OWN_WR;
    if (rd_req) return OWN_RD;
    return OWN_IDLE;
  endfunction

  function automatic logic [63:0] exp_bus();
    logic [3:0]        c;
    logic [1:0]        b;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              oe;
    c = 4'b0111; b = 2'b11; a = '1; d = '0; oe = 1'b0;
    if (sys_rst || m_owner == OWN_INIT) begin
      c = init_cmd; b = init_bank; a = init_addr;
    end else if (m_owner == OWN_ATREF) begin
      c = atref_cmd; b = atref_bank; a = atref_addr;
    end else if (m_owner == OWN_WR) begin
      c = wr_cmd; b = wr_bank; a = wr_addr; d = wr_dq; oe = wr_dq_oe;
    end else if (m_owner == OWN_RD) begin
      c = rd_cmd; b = rd_bank; a = rd_addr;
    end
    return 64'({c, b, a, d, oe});
  endfunction

  // Advance the model across one rising edge using the inputs seen at that edge
  task automatic model_edge();
    bit done;
    if (sys_rst) begin
      m_owner = OWN_INIT; m_cool = 0; m_rd_turn = 0;
      return;
    end
    done = (m_owner == OWN_ATREF && atref_end) ||
           (m_owner == OWN_WR && wr_end) || (m_owner == OWN_RD && rd_end);
    if (m_owner == OWN_INIT) begin
      if (init_end) m_owner = OWN_IDLE;
    end else if (done) begin
      m_owner = OWN_IDLE;
    end else if (m_owner == OWN_IDLE && m_grant != OWN_IDLE) begin
      m_owner = m_grant;
      if (m_grant == OWN_WR || m_grant == OWN_RD) m_rd_turn = !m_rd_turn;
    end
    m_cool = done;
  endtask

  task automatic drive_random(input int cyc);
    sys_rst    = (cyc < 3) || ($urandom_range(0, 199) == 0);
    init_end   = ($urandom_range(0, 5) == 0);
    init_cmd   = 4'($urandom); init_bank  = 2'($urandom); init_addr  = ADDR_W'($urandom);
    atref_cmd  = 4'($urandom); atref_bank = 2'($urandom); atref_addr = ADDR_W'($urandom);
    wr_cmd     = 4'($urandom); wr_bank    = 2'($urandom); wr_addr    = ADDR_W'($urandom);
    rd_cmd     = 4'($urandom); rd_bank    = 2'($urandom); rd_addr    = ADDR_W'($urandom);
    wr_dq      = DATA_W'($urandom);
    wr_dq_oe   = 1'($urandom);
    atref_req  = ($urandom_range(0, 4) == 0);
    wr_req     = ($urandom_range(0, 2) != 0);
    rd_req     = ($urandom_range(0, 2) != 0);
    atref_end  = ($urandom_range(0, 4) == 0);
    wr_end     = ($urandom_range(0, 4) == 0);
    rd_end     = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    m_owner = OWN_INIT; m_cool = 0; m_rd_turn = 0; m_grant = OWN_IDLE;
    drive_random(0);
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge sys_clk);
      model_edge();
      #1;
      drive_random(cyc + 1);
      #3;
      m_grant = pick_grant();
      check("grant", 64'({atref_en, wr_en, rd_en}),
            64'({m_grant == OWN_ATREF, m_grant == OWN_WR, m_grant == OWN_RD}));
      check("bus", 64'({sdram_cmd, sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe}),
            exp_bus());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
